// File: rtl/dht11_pkg.sv
// -----------------------------------------------------------------------------
// dht11_pkg
// Shared definitions for the DHT11 single-wire protocol blocks: the responder
// state enum, the frame length, the default protocol timing in microseconds
// (also used by the DHT11 reader) and the frame checksum helper.
// -----------------------------------------------------------------------------
package dht11_pkg;

    // Responder states, from start-pulse watch through the trailing end-low
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOST_LOW,
        ST_HOST_REL,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_END_LOW,
        ST_IDLE_WAIT
    } dht_state_e;

    localparam int FRAME_BITS = 40;

    // Default protocol timing, all in microseconds
    localparam int DHT_START_MIN_US  = 18000;
    localparam int DHT_WAIT_US       = 30;
    localparam int DHT_RESP_LOW_US   = 80;
    localparam int DHT_RESP_HIGH_US  = 80;
    localparam int DHT_BIT_LOW_US    = 50;
    localparam int DHT_BIT0_HIGH_US  = 26;
    localparam int DHT_BIT1_HIGH_US  = 70;

    // Width of the microsecond counter; wide enough for the longest start pulse
    localparam int US_CNT_W = 16;

    // Sum of the four data bytes, carried in 10 bits so no carry is lost
    // before the deliberate truncation back to one byte
    function automatic logic [7:0] dhtChecksum(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [7:0] c,
                                               input logic [7:0] d);
        logic [9:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[7:0];
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// -----------------------------------------------------------------------------
// dht11_us_tick
// Microsecond prescaler. Counts clock cycles and raises us_tick_o for one cycle
// at the end of every TICKS_PER_US-cycle window. restart_i realigns the window
// so the next tick comes exactly TICKS_PER_US cycles later.
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   restart_i  in  synchronous restart of the prescaler window
//   us_tick_o  out one-cycle pulse closing each microsecond
// -----------------------------------------------------------------------------
module dht11_us_tick #(
    parameter int TICKS_PER_US = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart_i,
    output logic us_tick_o
);

    localparam int CW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

    logic [CW-1:0] cnt_q;

    assign us_tick_o = (cnt_q == CW'(TICKS_PER_US - 1));

    // Window counter: wraps after the tick cycle, or is forced back to the
    // start of a window whenever the owner enters a new phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (restart_i || us_tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/dht11_sensor_emulator.sv
// -----------------------------------------------------------------------------
// dht11_sensor_emulator
// Responding end of the DHT11 single-wire protocol. Detects a host start pulse
// on the open-drain line, then drives the response preamble and a 40-bit frame
// (humidity, temperature, checksum) built from the parallel value inputs.
//   clk            in  system clock
//   reset_n        in  asynchronous active-low reset
//   dht_line_in    in  sensed data line level, asynchronous to clk
//   hum_int/hum_dec/temp_int/temp_dec  in  values for the next frame
//   dht_drive_low  out 1 pulls the line low, 0 releases it
//   busy           out high from start acceptance through the end-low phase
//   frame_done     out one-cycle pulse when the end-low phase completes
// -----------------------------------------------------------------------------
module dht11_sensor_emulator
    import dht11_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int START_MIN_US  = DHT_START_MIN_US,
    parameter int WAIT_US       = DHT_WAIT_US,
    parameter int RESP_LOW_US   = DHT_RESP_LOW_US,
    parameter int RESP_HIGH_US  = DHT_RESP_HIGH_US,
    parameter int BIT_LOW_US    = DHT_BIT_LOW_US,
    parameter int BIT0_HIGH_US  = DHT_BIT0_HIGH_US,
    parameter int BIT1_HIGH_US  = DHT_BIT1_HIGH_US
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dht_line_in,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       dht_drive_low,
    output logic       busy,
    output logic       frame_done
);

    localparam int TICKS_PER_US = CLK_HZ / 1_000_000;

    logic                  lineMeta_q;
    logic                  lineSync_q;
    logic                  lineDly_q;
    logic                  lineFall;
    logic                  lineRise;

    dht_state_e            state_q;
    dht_state_e            state_d;
    logic [US_CNT_W-1:0]   usCnt_q;
    logic [5:0]            bitIdx_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic                  driveLow_q;
    logic                  busy_q;
    logic                  frameDone_q;

    logic [US_CNT_W-1:0]   phaseDur;
    logic                  phaseDone;
    logic                  curBit;
    logic                  restart;
    logic                  usTick;

    // Two-flop synchronizer plus a delayed copy for edge detection. The flops
    // reset to the idle-high line level so leaving reset never looks like a
    // start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lineMeta_q <= 1'b1;
            lineSync_q <= 1'b1;
            lineDly_q  <= 1'b1;
        end else begin
            lineMeta_q <= dht_line_in;
            lineSync_q <= lineMeta_q;
            lineDly_q  <= lineSync_q;
        end
    end

    assign lineFall = lineDly_q & ~lineSync_q;
    assign lineRise = ~lineDly_q & lineSync_q;

    assign curBit = frame_q[bitIdx_q];

    // Length of the timed phase we are currently in; the high slot of a data
    // bit is what carries its value
    always_comb begin
        phaseDur = US_CNT_W'(WAIT_US);
        case (state_q)
            ST_RESP_LOW:            phaseDur = US_CNT_W'(RESP_LOW_US);
            ST_RESP_HIGH:           phaseDur = US_CNT_W'(RESP_HIGH_US);
            ST_BIT_LOW, ST_END_LOW: phaseDur = US_CNT_W'(BIT_LOW_US);
            ST_BIT_HIGH:            phaseDur = curBit ? US_CNT_W'(BIT1_HIGH_US)
                                                      : US_CNT_W'(BIT0_HIGH_US);
            default:                phaseDur = US_CNT_W'(WAIT_US);
        endcase
    end

    // A timed phase ends on the tick that closes its last microsecond, so the
    // phase occupies exactly duration x TICKS_PER_US cycles
    assign phaseDone = usTick && (usCnt_q == phaseDur - US_CNT_W'(1));

    // Next-state decision. The line is only looked at while idle, measuring
    // the host pulse, or waiting for the line to come back high after a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (lineFall) state_d = ST_HOST_LOW;
            end
            ST_HOST_LOW: begin
                if (lineRise) begin
                    state_d = (usCnt_q >= US_CNT_W'(START_MIN_US)) ? ST_HOST_REL : ST_IDLE;
                end
            end
            ST_HOST_REL: begin
                if (phaseDone) state_d = ST_RESP_LOW;
            end
            ST_RESP_LOW: begin
                if (phaseDone) state_d = ST_RESP_HIGH;
            end
            ST_RESP_HIGH: begin
                if (phaseDone) state_d = ST_BIT_LOW;
            end
            ST_BIT_LOW: begin
                if (phaseDone) state_d = ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
                if (phaseDone) state_d = (bitIdx_q == 6'd0) ? ST_END_LOW : ST_BIT_LOW;
            end
            ST_END_LOW: begin
                if (phaseDone) state_d = ST_IDLE_WAIT;
            end
            ST_IDLE_WAIT: begin
                if (lineSync_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every state entry realigns the microsecond prescaler and counter
    assign restart = (state_d != state_q);

    dht11_us_tick #(
        .TICKS_PER_US (TICKS_PER_US)
    ) uUsTick (
        .clk       (clk),
        .reset_n   (reset_n),
        .restart_i (restart),
        .us_tick_o (usTick)
    );

    // State register with outputs decoded from the next state, so the line
    // drive, busy and the done pulse all change on the same edge as the state
    // and come straight out of flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            driveLow_q  <= 1'b0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            driveLow_q  <= (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW) ||
                           (state_d == ST_END_LOW);
            busy_q      <= (state_d == ST_HOST_REL) || (state_d == ST_RESP_LOW) ||
                           (state_d == ST_RESP_HIGH) || (state_d == ST_BIT_LOW) ||
                           (state_d == ST_BIT_HIGH) || (state_d == ST_END_LOW);
            frameDone_q <= (state_q == ST_END_LOW) && phaseDone;
        end
    end

    // Microsecond counter. It saturates rather than wrapping so that a very
    // long host pulse still reads as long enough to be a start request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            usCnt_q <= '0;
        end else if (restart) begin
            usCnt_q <= '0;
        end else if (usTick && (state_q != ST_IDLE) && (state_q != ST_IDLE_WAIT) &&
                     (usCnt_q != {US_CNT_W{1'b1}})) begin
            usCnt_q <= usCnt_q + US_CNT_W'(1);
        end
    end

    // Frame snapshot taken once, when the start pulse is accepted, so input
    // changes during a frame only show up in the following one. The bit index
    // walks MSB first through the snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_q  <= '0;
            bitIdx_q <= '0;
        end else begin
            if ((state_q == ST_HOST_LOW) && (state_d == ST_HOST_REL)) begin
                frame_q <= {hum_int, hum_dec, temp_int, temp_dec,
                            dhtChecksum(hum_int, hum_dec, temp_int, temp_dec)};
            end
            if ((state_q == ST_RESP_HIGH) && phaseDone) begin
                bitIdx_q <= 6'(FRAME_BITS - 1);
            end else if ((state_q == ST_BIT_HIGH) && phaseDone && (bitIdx_q != 6'd0)) begin
                bitIdx_q <= bitIdx_q - 6'd1;
            end
        end
    end

    assign dht_drive_low = driveLow_q;
    assign busy          = busy_q;
    assign frame_done    = frameDone_q;

endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// -----------------------------------------------------------------------------
// tb_dht11_sensor_emulator
// Bench for the DHT11 responder at 1 MHz (one cycle per microsecond) with a
// 100 us start threshold. A host process issues start pulses and pushes the
// frame it expects onto a queue; an independent monitor decodes the line
// waveform and compares each decoded frame against the queue head.
// -----------------------------------------------------------------------------
module tb_dht11_sensor_emulator;

    localparam int START_MIN = 100;
    localparam int WAIT_T    = 30;
    localparam int PRE_LOW   = 80;
    localparam int PRE_HIGH  = 80;
    localparam int SLOT_LOW  = 50;
    localparam int HIGH0     = 26;
    localparam int HIGH1     = 70;
    localparam int SYNC_LAT  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       hostLow;
    logic       extHold;
    logic       dhtLine;
    logic [7:0] humInt, humDec, tempInt, tempDec;
    logic       dhtDriveLow;
    logic       busy;
    logic       frameDone;

    int         testsRun    = 0;
    int         testsFailed = 0;
    longint     expQ[$];
    int         expDone       = 0;
    int         frameDoneCnt  = 0;

    logic       prevDrive = 1'b0;
    int         runLen    = 0;
    int         monPhase  = 0;
    int         monBits   = 0;
    longint     monFrame  = 0;

    // Open-drain line: anyone pulling low wins, otherwise the pull-up holds it high
    assign dhtLine = ~(hostLow | extHold | dhtDriveLow);

    always #5 clk = ~clk;

    dht11_sensor_emulator #(
        .CLK_HZ       (1_000_000),
        .START_MIN_US (START_MIN)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dht_line_in   (dhtLine),
        .hum_int       (humInt),
        .hum_dec       (humDec),
        .temp_int      (tempInt),
        .temp_dec      (tempDec),
        .dht_drive_low (dhtDriveLow),
        .busy          (busy),
        .frame_done    (frameDone)
    );

    // Single place where a comparison is counted and reported
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference frame: four bytes MSB first, then their sum modulo 256
    function automatic longint modelFrame(input int h, input int hd, input int t, input int td);
        longint chk;
        chk = (h + hd + t + td) % 256;
        return (longint'(h) << 32) + (longint'(hd) << 24) + (longint'(t) << 16) +
               (longint'(td) << 8) + chk;
    endfunction

    // A low run of the sensor drive has just finished
    task automatic lowRunEnded(input int len);
        if (monPhase == 0) begin
            checkOutput("preamble_low", len, PRE_LOW);
            monPhase = 1;
        end else if (monPhase == 2) begin
            if (monBits < 40) begin
                checkOutput("bit_low", len, SLOT_LOW);
            end else begin
                checkOutput("end_low", len, SLOT_LOW);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_frame", monFrame, -1);
                end else begin
                    checkOutput("frame", monFrame, expQ.pop_front());
                end
                monPhase = 0;
                monBits  = 0;
            end
        end
    endtask

    // A released (high) run has just finished; in the data phase it carries a bit
    task automatic highRunEnded(input int len);
        if (monPhase == 1) begin
            checkOutput("preamble_high", len, PRE_HIGH);
            monPhase = 2;
            monFrame = 0;
        end else if (monPhase == 2 && monBits < 40) begin
            if (len == HIGH1) begin
                monFrame = (monFrame << 1) + 1;
            end else begin
                if (len != HIGH0) checkOutput("bit_high_len", len, HIGH0);
                monFrame = monFrame << 1;
            end
            monBits++;
        end
    endtask

    // Monitor: measures run lengths of the sensor drive on the falling clock edge
    always @(negedge clk) begin
        if (!reset_n) begin
            prevDrive = 1'b0;
            runLen    = 0;
            monPhase  = 0;
            monBits   = 0;
        end else begin
            if (frameDone) frameDoneCnt++;
            if (dhtDriveLow == prevDrive) begin
                runLen++;
            end else begin
                if (prevDrive) lowRunEnded(runLen);
                else           highRunEnded(runLen);
                prevDrive = dhtDriveLow;
                runLen    = 1;
            end
        end
    end

    // Host start pulse; a long enough pulse queues the expected frame and
    // returns once the response preamble has started
    task automatic applyStimulus(input int pulseUs, input int h, input int hd,
                                 input int t, input int td);
        int lat;
        int bad;
        humInt  = 8'(h);
        humDec  = 8'(hd);
        tempInt = 8'(t);
        tempDec = 8'(td);
        @(negedge clk);
        hostLow = 1'b1;
        repeat (pulseUs) @(negedge clk);
        hostLow = 1'b0;
        if (pulseUs >= START_MIN) begin
            expQ.push_back(modelFrame(h, hd, t, td));
            expDone++;
            lat = 0;
            while (!dhtDriveLow && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            checkOutput("resp_latency", lat, WAIT_T + SYNC_LAT);
            checkOutput("busy_in_frame", busy, 1);
        end else begin
            bad = 0;
            repeat (200) begin
                @(negedge clk);
                if (dhtDriveLow || busy) bad++;
            end
            checkOutput("runt_ignored", bad, 0);
        end
    endtask

    task automatic waitFrameDone();
        int n;
        n = 0;
        while (!frameDone && n < 10000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_done_seen", frameDone, 1);
        checkOutput("busy_cleared", busy, 0);
        repeat (5) @(negedge clk);
        checkOutput("frame_done_count", frameDoneCnt, expDone);
    endtask

    // Wait until the monitor has decoded a given number of bits and the
    // sensor is in a low slot
    task automatic waitMonBits(input int bits);
        int n;
        n = 0;
        while (!(monBits == bits && dhtDriveLow) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_bit", monBits, bits);
    endtask

    initial begin
        int bad;
        reset_n = 1'b0;
        hostLow = 1'b0;
        extHold = 1'b0;
        humInt  = '0;
        humDec  = '0;
        tempInt = '0;
        tempDec = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_drive", dhtDriveLow, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", frameDone, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Runt pulse
        applyStimulus(50, 8'h11, 8'h22, 8'h33, 8'h44);

        // Reference frame and checksum wrap-around
        applyStimulus(120, 8'h37, 8'h00, 8'h1A, 8'h05);
        waitFrameDone();
        applyStimulus(120, 8'hFF, 8'hFF, 8'hFF, 8'h03);
        waitFrameDone();

        // Input change mid-frame only affects the following frame
        applyStimulus(130, 8'h11, 8'h22, 8'h1A, 8'h33);
        tempInt = 8'h20;
        waitFrameDone();
        applyStimulus(130, 8'h11, 8'h22, 8'h20, 8'h33);
        waitFrameDone();

        // Reset in the middle of the data bits
        applyStimulus(150, $urandom_range(255), $urandom_range(255),
                      $urandom_range(255), $urandom_range(255));
        waitMonBits(20);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midreset_drive", dhtDriveLow, 0);
        checkOutput("midreset_busy", busy, 0);
        expQ.delete();
        expDone--;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        applyStimulus(120, 8'h37, 8'h00, 8'h1A, 8'h05);
        waitFrameDone();

        // Line held low past the end-low phase must not look like a new start
        applyStimulus(120, $urandom_range(255), $urandom_range(255),
                      $urandom_range(255), $urandom_range(255));
        waitMonBits(40);
        extHold = 1'b1;
        waitFrameDone();
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (dhtDriveLow || busy) bad++;
        end
        checkOutput("held_low_no_resp", bad, 0);
        extHold = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (dhtDriveLow || busy) bad++;
        end
        checkOutput("release_no_resp", bad, 0);
        applyStimulus(140, 8'h5A, 8'hA5, 8'h0F, 8'hF0);
        waitFrameDone();

        // Randomized frames and pulse lengths
        for (int i = 0; i < 2; i++) begin
            applyStimulus(110 + $urandom_range(150), $urandom_range(255), $urandom_range(255),
                          $urandom_range(255), $urandom_range(255));
            waitFrameDone();
        end
        applyStimulus(20 + $urandom_range(60), 8'h01, 8'h02, 8'h03, 8'h04);

        checkOutput("queue_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog so a stuck design still produces a verdict
    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        testsFailed++;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
